// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU stage: opcodes, FSM states and
// the data-width derivation from the output word width.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 5;

  // The top bit of the output word is the overflow flag, the rest is data.
  function automatic int dw_of(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle over DW cycles.
// product presents the accumulator value after the current iteration, so the
// sequencing FSM can capture the final product on the same edge done is high.
module alu_mul_seq #(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  output logic              done,
  output logic [2*DW-1:0]   product
);

  localparam int PW = 2 * DW;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic          active;
  logic [PW-1:0] acc_next;

  // Accumulator value once this cycle's partial product has been added.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign done    = active && (cnt == CW'(DW - 1));
  assign product = acc_next;

  // Load operands on request, then step one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{DW{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU stage: captures Op/A/B on Start, computes in one cycle (or DW
// cycles for multiply) and presents {overflow, value} with a one-cycle Valid.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic [2:0]             Op,
  input  logic [dw_of(WIDTH)-1:0] A,
  input  logic [dw_of(WIDTH)-1:0] B,
  output logic                   Busy,
  output logic                   Valid,
  output logic [WIDTH-1:0]       Result
);

  localparam int DW = dw_of(WIDTH);

  state_t        state;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  logic [DW-1:0]   exec_value;
  logic            exec_ovf;
  logic [DW:0]     sum;
  logic [2*DW-1:0] shl;

  logic            mul_load;
  logic            mul_done;
  logic [2*DW-1:0] mul_product;

  assign mul_load = (state == S_IDLE) && Start && (Op == OP_MUL);

  alu_mul_seq #(.DW(DW)) u_mul (
    .clk     (Clk),
    .rst     (Rst),
    .load    (mul_load),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle operations computed from the latched operands.
  always_comb begin
    exec_value = '0;
    exec_ovf   = 1'b0;
    sum        = '0;
    shl        = '0;
    case (op_q)
      OP_ADD: begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        exec_value = sum[DW-1:0];
        exec_ovf   = sum[DW];
      end
      OP_SUB: begin
        exec_value = a_q - b_q;
        exec_ovf   = (a_q < b_q);
      end
      OP_AND: exec_value = a_q & b_q;
      OP_OR:  exec_value = a_q | b_q;
      OP_XOR: exec_value = a_q ^ b_q;
      OP_NOT: exec_value = ~a_q;
      OP_SHL: begin
        shl        = {{DW{1'b0}}, a_q} << b_q[1:0];
        exec_value = shl[DW-1:0];
        exec_ovf   = |shl[2*DW-1:DW];
      end
      default: begin
        exec_value = '0;
        exec_ovf   = 1'b0;
      end
    endcase
  end

  // Control FSM with registered Busy/Valid/Result; reset aborts any operation.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      Busy   <= 1'b0;
      Valid  <= 1'b0;
      Result <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q  <= Op;
            a_q   <= A;
            b_q   <= B;
            Busy  <= 1'b1;
            state <= (Op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          Result <= {exec_ovf, exec_value};
          Valid  <= 1'b1;
          Busy   <= 1'b0;
          state  <= S_IDLE;
        end
        S_MUL: begin
          if (mul_done) begin
            Result <= {|mul_product[2*DW-1:DW], mul_product[DW-1:0]};
            Valid  <= 1'b1;
            Busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: a latency-countdown reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_alu_seq_core;

  localparam int WIDTH = 5;
  localparam int DW    = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [2:0]    Op;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          Busy;
  logic          Valid;
  logic [WIDTH-1:0] Result;

  int total_checks = 0;
  int pass_checks  = 0;
  bit check_en     = 1'b0;

  logic       m_busy    = 1'b0;
  logic       m_valid   = 1'b0;
  logic [4:0] m_result  = '0;
  logic [4:0] m_pending = '0;
  int         m_left    = 0;

  alu_seq_core #(.WIDTH(WIDTH)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Valid  (Valid),
    .Result (Result)
  );

  always #5 Clk = ~Clk;

  // Expected {ovf, value} from plain integer arithmetic.
  function automatic logic [4:0] golden(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    r  = 0;
    case (op)
      3'd0: begin r = ia + ib; return {r > 15, 4'(r % 16)}; end
      3'd1: return {ia < ib, 4'((ia - ib + 16) % 16)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, 4'(15 - ia)};
      3'd6: begin r = ia * ib; return {r > 15, 4'(r % 16)}; end
      default: begin r = ia << (ib % 4); return {r > 15, 4'(r % 16)}; end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) pass_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    Op    = 3'($urandom_range(0, 7));
    A     = 4'($urandom_range(0, 15));
    B     = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (Valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) checkOutput("valid_timeout", {31'd0, Valid}, 32'd1);
  endtask

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Valid === 1'b1) cnt++;
    end
  endtask

  // Reference model: an accepted op completes after a fixed latency.
  always @(posedge Clk) begin
    if (Rst) begin
      m_busy   = 1'b0;
      m_valid  = 1'b0;
      m_result = '0;
      m_left   = 0;
    end else begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_result = m_pending;
          m_valid  = 1'b1;
          m_busy   = 1'b0;
        end
      end else if (Start) begin
        m_pending = golden(Op, A, B);
        m_left    = (Op == 3'd6) ? DW : 1;
        m_busy    = 1'b1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge Clk) begin
    if (check_en) begin
      checkOutput("cyc_valid",  {31'd0, Valid}, {31'd0, m_valid});
      checkOutput("cyc_busy",   {31'd0, Busy},  {31'd0, m_busy});
      checkOutput("cyc_result", {27'd0, Result}, {27'd0, m_result});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] t_op [6];
    logic [3:0] t_a  [6];
    logic [3:0] t_b  [6];
    logic [4:0] t_exp[6];
    int lat, nv;

    t_op[0] = 3'd0; t_a[0] = 4'd9;  t_b[0] = 4'd8;  t_exp[0] = 5'b1_0001;
    t_op[1] = 3'd1; t_a[1] = 4'd3;  t_b[1] = 4'd5;  t_exp[1] = 5'b1_1110;
    t_op[2] = 3'd3; t_a[2] = 4'd12; t_b[2] = 4'd3;  t_exp[2] = 5'b0_1111;
    t_op[3] = 3'd5; t_a[3] = 4'd5;  t_b[3] = 4'd0;  t_exp[3] = 5'b0_1010;
    t_op[4] = 3'd7; t_a[4] = 4'd9;  t_b[4] = 4'd1;  t_exp[4] = 5'b1_0010;
    t_op[5] = 3'd7; t_a[5] = 4'd3;  t_b[5] = 4'd2;  t_exp[5] = 5'b0_1100;

    // Reset held two cycles with Start asserted; the Start must be dropped.
    Rst = 1'b1; Start = 1'b1; Op = 3'd0; A = 4'd1; B = 4'd1;
    repeat (2) @(negedge Clk);
    check_en = 1'b1;
    checkOutput("rst_result", {27'd0, Result}, 32'd0);
    checkOutput("rst_valid",  {31'd0, Valid},  32'd0);
    checkOutput("rst_busy",   {31'd0, Busy},   32'd0);
    Rst = 1'b0; Start = 1'b0;
    count_valids(3, nv);
    checkOutput("rst_no_valid", nv, 0);

    // Single-cycle ops from the directed table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t_op[i], t_a[i], t_b[i]);
      checkOutput("exec_busy", {31'd0, Busy}, 32'd1);
      wait_valid(lat);
      checkOutput("exec_latency", lat, 1);
      checkOutput("exec_result", {27'd0, Result}, {27'd0, t_exp[i]});
      checkOutput("exec_model",  {27'd0, m_result}, {27'd0, t_exp[i]});
      @(negedge Clk);
      checkOutput("exec_valid_drop", {31'd0, Valid}, 32'd0);
    end

    // Multiply: 3*5 and 15*15.
    applyStimulus(3'd6, 4'd3, 4'd5);
    wait_valid(lat);
    checkOutput("mul_latency", lat, 4);
    checkOutput("mul_3x5", {27'd0, Result}, {27'd0, 5'b0_1111});
    @(negedge Clk);
    applyStimulus(3'd6, 4'd15, 4'd15);
    wait_valid(lat);
    checkOutput("mul_latency2", lat, 4);
    checkOutput("mul_15x15", {27'd0, Result}, {27'd0, 5'b1_0001});
    @(negedge Clk);

    // Start during a multiply is ignored.
    applyStimulus(3'd6, 4'd2, 4'd3);
    @(negedge Clk);
    applyStimulus(3'd0, 4'd1, 4'd1);
    wait_valid(lat);
    checkOutput("rej_latency", lat, 2);
    checkOutput("rej_result", {27'd0, Result}, {27'd0, 5'b0_0110});
    count_valids(6, nv);
    checkOutput("rej_single_valid", nv, 0);

    // Second Start lands on the edge that ends the Valid cycle and is accepted.
    applyStimulus(3'd0, 4'd1, 4'd1);
    @(negedge Clk);
    checkOutput("b2b_valid1", {31'd0, Valid}, 32'd1);
    checkOutput("b2b_result1", {27'd0, Result}, {27'd0, 5'b0_0010});
    applyStimulus(3'd4, 4'd5, 4'd3);
    checkOutput("b2b_gap", {31'd0, Valid}, 32'd0);
    @(negedge Clk);
    checkOutput("b2b_valid2", {31'd0, Valid}, 32'd1);
    checkOutput("b2b_result2", {27'd0, Result}, {27'd0, 5'b0_0110});
    @(negedge Clk);

    // Reset in the middle of a multiply aborts it without a Valid.
    applyStimulus(3'd6, 4'd7, 4'd7);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checkOutput("abort_result", {27'd0, Result}, 32'd0);
    checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
    count_valids(5, nv);
    checkOutput("abort_no_valid", nv, 0);
    applyStimulus(3'd2, 4'd12, 4'd10);
    wait_valid(lat);
    checkOutput("abort_then_and", {27'd0, Result}, {27'd0, 5'b0_1000});
    repeat (2) @(negedge Clk);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
